// File: rtl/riscblade_pkg.sv
// Shared definitions for the riscblade multicycle datapath: width,
// ALU operation encodings and instruction-register field positions.
package riscblade_pkg;

   localparam int DATA_W = 16;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   // IR layout: rs2 | rs1 | rd | opcode
   localparam int RS2_MSB = 15;
   localparam int RS2_LSB = 12;
   localparam int RS1_MSB = 11;
   localparam int RS1_LSB = 8;
   localparam int RD_MSB  = 7;
   localparam int RD_LSB  = 4;
   localparam int OP_MSB  = 3;
   localparam int OP_LSB  = 0;

endpackage

// File: rtl/alu16.sv
// Combinational add/subtract ALU with zero flag; carry and borrow are dropped.
module alu16
   import riscblade_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             aluop,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero
);

   always_comb begin
      if (aluop == ALU_SUB) alu_out = srca - srcb;
      else                  alu_out = srca + srcb;
   end

   assign zero = (alu_out == '0);

endmodule

// File: rtl/alu_datapath_regs.sv
// Multicycle datapath storage (IR, MDR, A, B, ALUOut) around the ALU.
// Operand muxes live outside; only IR has a load enable.
module alu_datapath_regs
   import riscblade_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] mem_out,
   input  logic             iren,
   input  logic [WIDTH-1:0] reg_a,
   input  logic [WIDTH-1:0] reg_b,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             aluop,
   output logic [WIDTH-1:0] inst_out,
   output logic [3:0]       rs1,
   output logic [3:0]       rs2,
   output logic [3:0]       rd,
   output logic [3:0]       opcode,
   output logic [WIDTH-1:0] mdr_out,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] aluout_reg,
   output logic             zero
);

   alu16 #(.WIDTH(WIDTH)) u_alu (
      .srca    (srca),
      .srcb    (srcb),
      .aluop   (aluop),
      .alu_out (alu_out),
      .zero    (zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         inst_out   <= '0;
         mdr_out    <= '0;
         a_out      <= '0;
         b_out      <= '0;
         aluout_reg <= '0;
      end else begin
         if (iren) inst_out <= mem_out;
         mdr_out    <= mem_out;
         a_out      <= reg_a;
         b_out      <= reg_b;
         aluout_reg <= alu_out;
      end
   end

   assign rs2    = inst_out[RS2_MSB:RS2_LSB];
   assign rs1    = inst_out[RS1_MSB:RS1_LSB];
   assign rd     = inst_out[RD_MSB:RD_LSB];
   assign opcode = inst_out[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_alu_datapath_regs.sv
// Directed bench for alu_datapath_regs with hand-computed expectations.
module tb_alu_datapath_regs;

   logic        clock;
   logic        reset;
   logic [15:0] mem_out;
   logic        iren;
   logic [15:0] reg_a;
   logic [15:0] reg_b;
   logic [15:0] srca;
   logic [15:0] srcb;
   logic        aluop;
   logic [15:0] inst_out;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [3:0]  rd;
   logic [3:0]  opcode;
   logic [15:0] mdr_out;
   logic [15:0] a_out;
   logic [15:0] b_out;
   logic [15:0] alu_out;
   logic [15:0] aluout_reg;
   logic        zero;

   int n_cmp = 0;
   int n_err = 0;

   alu_datapath_regs dut (
      .clock      (clock),
      .reset      (reset),
      .mem_out    (mem_out),
      .iren       (iren),
      .reg_a      (reg_a),
      .reg_b      (reg_b),
      .srca       (srca),
      .srcb       (srcb),
      .aluop      (aluop),
      .inst_out   (inst_out),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .opcode     (opcode),
      .mdr_out    (mdr_out),
      .a_out      (a_out),
      .b_out      (b_out),
      .alu_out    (alu_out),
      .aluout_reg (aluout_reg),
      .zero       (zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      mem_out = 16'hFFFF;
      iren    = 1'b1;
      reg_a   = 16'h0000;
      reg_b   = 16'h0000;
      srca    = 16'h0003;
      srcb    = 16'h0004;
      aluop   = 1'b0;
      step();
      reset = 1'b0;

      // reset: ALU showed 7 at the edge, but ALUOut must still clear
      check("rst_inst",   inst_out,   16'h0000);
      check("rst_mdr",    mdr_out,    16'h0000);
      check("rst_a",      a_out,      16'h0000);
      check("rst_b",      b_out,      16'h0000);
      check("rst_aluout", aluout_reg, 16'h0000);
      check("rst_fields", {rs2, rs1, rd, opcode}, 16'h0000);

      mem_out = 16'h1234;
      iren    = 1'b1;
      step();
      check("ir_load",  inst_out, 16'h1234);
      check("ir_rs2",   {12'h0, rs2},    16'h0001);
      check("ir_rs1",   {12'h0, rs1},    16'h0002);
      check("ir_rd",    {12'h0, rd},     16'h0003);
      check("ir_op",    {12'h0, opcode}, 16'h0004);
      check("mdr_same", mdr_out,  16'h1234);
      check("aluout_7", aluout_reg, 16'h0007);

      mem_out = 16'hABCD;
      iren    = 1'b0;
      step();
      check("ir_hold",  inst_out, 16'h1234);
      check("mdr_new",  mdr_out,  16'hABCD);
      mem_out = 16'h0F0F;
      step();
      check("ir_hold2", inst_out, 16'h1234);
      check("mdr_next", mdr_out,  16'h0F0F);

      reg_a = 16'h0005;
      reg_b = 16'h0007;
      #1;
      check("a_before", a_out, 16'h0000);
      step();
      check("a_load", a_out, 16'h0005);
      check("b_load", b_out, 16'h0007);
      reg_a = 16'h0009;
      reg_b = 16'h0100;
      step();
      check("a_next", a_out, 16'h0009);
      check("b_next", b_out, 16'h0100);

      srca  = 16'hFFFF;
      srcb  = 16'h0001;
      aluop = 1'b0;
      #1;
      check("add_wrap", alu_out, 16'h0000);
      check("add_zero", {15'h0, zero}, 16'h0001);
      step();
      check("add_wrap_reg", aluout_reg, 16'h0000);

      srca = 16'h0010;
      srcb = 16'h0002;
      #1;
      check("pc_inc",      alu_out, 16'h0012);
      check("pc_inc_zero", {15'h0, zero}, 16'h0000);
      check("reg_lags",    aluout_reg, 16'h0000);
      step();
      check("pc_inc_reg",  aluout_reg, 16'h0012);

      srca  = 16'h0003;
      srcb  = 16'h0005;
      aluop = 1'b1;
      #1;
      check("sub_neg",      alu_out, 16'hFFFE);
      check("sub_neg_zero", {15'h0, zero}, 16'h0000);
      srca = 16'h0042;
      srcb = 16'h0042;
      #1;
      check("sub_eq",      alu_out, 16'h0000);
      check("sub_eq_zero", {15'h0, zero}, 16'h0001);
      srca = 16'h8000;
      srcb = 16'h0001;
      #1;
      check("sub_big", alu_out, 16'h7FFF);

      mem_out = 16'h5A5A;
      iren    = 1'b1;
      reg_a   = 16'h1111;
      reg_b   = 16'h2222;
      srca    = 16'h0100;
      srcb    = 16'h0023;
      aluop   = 1'b0;
      step();
      check("pre_inst",   inst_out,   16'h5A5A);
      check("pre_aluout", aluout_reg, 16'h0123);
      check("pre_a",      a_out,      16'h1111);

      reset   = 1'b1;
      mem_out = 16'hFFFF;
      #1;
      check("rst_alu_live", alu_out, 16'h0123);
      step();
      check("mid_inst",   inst_out,   16'h0000);
      check("mid_mdr",    mdr_out,    16'h0000);
      check("mid_a",      a_out,      16'h0000);
      check("mid_b",      b_out,      16'h0000);
      check("mid_aluout", aluout_reg, 16'h0000);
      check("mid_alu",    alu_out,    16'h0123);
      reset = 1'b0;
      iren  = 1'b0;
      step();
      check("post_ir_hold", inst_out, 16'h0000);
      check("post_mdr",     mdr_out,  16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_datapath_regs.md
Name: alu_datapath_regs

Overview:
- Combines the 16-bit ALU with the multicycle datapath's storage registers: instruction register (IR), memory data register (MDR), A, B and ALUOut.
- Sits between the register file/memory and the external source-select muxes (SRCA, SRCB, PC, IorD, RegData).
- The muxes are external. This block receives already-selected ALU operands and presents both registered and combinational results.

Parameters:
- WIDTH, 16, datapath width of all registers, operands and the result.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_out  in  WIDTH  memory read data; feeds IR and MDR
- iren  in  1  IR load enable
- reg_a  in  WIDTH  register-file read port A; feeds A register
- reg_b  in  WIDTH  register-file read port B; feeds B register
- srca  in  WIDTH  ALU operand A, already selected by the external mux (PC or A_OUT)
- srcb  in  WIDTH  ALU operand B, already selected by the external mux (B_OUT, 2, or immediate)
- aluop  in  1  0 = add, 1 = subtract
- inst_out  out  WIDTH  IR contents
- rs1  out  4  inst_out[11:8]
- rs2  out  4  inst_out[15:12]
- rd  out  4  inst_out[7:4]
- opcode  out  4  inst_out[3:0]
- mdr_out  out  WIDTH  MDR contents
- a_out  out  WIDTH  A register contents
- b_out  out  WIDTH  B register contents
- alu_out  out  WIDTH  combinational ALU result
- aluout_reg  out  WIDTH  registered ALU result
- zero  out  1  combinational; 1 when alu_out == 0

Behaviour:
- Single clock domain: clock. Reset is synchronous and active-high on port reset.
- While reset is sampled high at a rising edge, IR, MDR, A, B and ALUOut all load 0. Reset overrides iren.
- After reset, inst_out, mdr_out, a_out, b_out and aluout_reg read 0, and rs1/rs2/rd/opcode read 0.
- MDR, A, B and ALUOut are generic registers with no enable. At every rising edge they load mem_out, reg_a, reg_b and alu_out respectively, so each has 1-cycle latency.
- IR loads mem_out at a rising edge only when iren = 1. Otherwise it holds its value indefinitely.
- ALU is purely combinational, with 0-cycle latency from srca/srcb/aluop.
  - aluop = 0: alu_out = (srca + srcb) mod 2^WIDTH; carry out is discarded.
  - aluop = 1: alu_out = (srca - srcb) mod 2^WIDTH, two's-complement wrap; no borrow flag.
- zero reflects the current combinational alu_out, not aluout_reg.
- aluout_reg captures the alu_out value present at the clock edge. Changing operands in the same cycle only affects the next capture.
- Simultaneous events:
  - iren = 1 with mem_out changing: IR takes the value sampled at the edge.
  - IR and MDR loading the same mem_out on one edge both capture it.
- Reset mid-operation clears all registers on that edge. The ALU output keeps following its inputs during reset.
- No X propagation from unused inputs: every register has a defined value after the first reset edge.

Decomposition:
- Shared package (riscblade_pkg):
  - WIDTH default
  - aluop encodings ALU_ADD = 1'b0, ALU_SUB = 1'b1
  - IR field bit positions (RS2 15:12, RS1 11:8, RD 7:4, OP 3:0)
- One natural sub-module: alu16, the combinational ALU (srca, srcb, aluop -> alu_out, zero).
- The registers are simple always-blocks in the top; a shared parameterised register with an optional enable is acceptable.

Test Plan:
- Reset: reset = 1 for one edge with mem_out = 16'hFFFF, iren = 1 -> all register outputs 0 after the edge; rs1/rs2/rd/opcode = 0.
- IR enable: mem_out = 16'h1234, iren = 1, one edge -> inst_out = 16'h1234, rs2 = 1, rs1 = 2, rd = 3, opcode = 4. Then mem_out = 16'hABCD, iren = 0 -> inst_out stays 16'h1234 while mdr_out = 16'hABCD.
- Generic registers: reg_a = 16'h0005, reg_b = 16'h0007 -> a_out = 5 and b_out = 7 one edge later; they change again next edge when the inputs change.
- ALU add/wrap: srca = 16'hFFFF, srcb = 16'h0001, aluop = 0 -> alu_out = 0 and zero = 1 immediately; aluout_reg = 0 after the edge. PC-increment case: srca = 16'h0010, srcb = 2 -> 16'h0012, zero = 0.
- ALU subtract: srca = 16'h0003, srcb = 16'h0005, aluop = 1 -> alu_out = 16'hFFFE, zero = 0. srca = srcb = 16'h0042 -> alu_out = 0, zero = 1.
- Reset mid-operation: registers loaded with nonzero values, reset asserted for one edge -> all registers 0. alu_out still equals srca + srcb during reset.
